sync_updown_counter: RTL and testbench

Synchronous modulo-N up/down counter with parallel load, built from per-bit toggle cells. It consumes the team's flip-flop primitives as its storage element and is the first multi-bit sequential stage above them. It drives count-dependent logic downstream and can be cascaded through its terminal-count output.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/t_cell.sv | 26 ++
 rtl/sync_updown_counter.sv | 83 ++++++++
 tb/tb_sync_updown_counter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and next-count arithmetic for the modulo-N up/down counter.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Next count in the direction given, wrapping at 0 and modulus-1.
   function automatic int unsigned next_count(input int unsigned q,
                                              input logic        up,
                                              input int unsigned modulus);
      int unsigned nxt;
      if (up == DIR_UP) begin
         nxt = (q == modulus - 1) ? 32'd0 : q + 32'd1;
      end else begin
         nxt = (q == 32'd0) ? modulus - 1 : q - 32'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/t_cell.sv
// 1-bit toggle flip-flop with synchronous active-low reset.
module t_cell (
   input  logic clk,
   input  logic reset,
   input  logic t,
   output logic q
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q ^ t;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/sync_updown_counter.sv
// Modulo-N up/down counter with parallel load, stored in per-bit toggle cells.
module sync_updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             err
);

   if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("sync_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_W     = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] q_cur;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] t_c;
   logic             at_max;
   logic             at_zero;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;

   assign at_max  = (q_cur == MAX_COUNT);
   assign at_zero = (q_cur == '0);

   // Next count: load beats count beats hold; reset is applied inside the cells.
   always_comb begin
      q_next = q_cur;
      wrap_d = 1'b0;
      err_d  = 1'b0;
      if (load) begin
         if ({1'b0, din} >= MOD_W) begin
            q_next = MAX_COUNT;
            err_d  = 1'b1;
         end else begin
            q_next = din;
         end
      end else if (en) begin
         q_next = WIDTH'(next_count(32'(q_cur), up, MODULUS));
         wrap_d = (up == DIR_UP) ? at_max : at_zero;
      end
   end

   // Toggle exactly the bits where the next value differs from the current one.
   assign t_c = q_next ^ q_cur;

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      t_cell u_bit (
         .clk   (clk),
         .reset (reset),
         .t     (t_c[i]),
         .q     (q_cur[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
         err_q  <= err_d;
      end
   end

   assign q    = q_cur;
   assign wrap = wrap_q;
   assign err  = err_q;
   assign tc   = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Scoreboard bench for sync_updown_counter (WIDTH=4, MODULUS=10) plus a two-stage cascade.
module tb_sync_updown_counter;

   logic       clk = 1'b0;
   logic       reset, en, up, load;
   logic [3:0] din;
   logic [3:0] q;
   logic       tc, wrap, err;

   logic       crst, cen;
   logic [3:0] c1_q, c2_q;
   logic       c1_tc, c2_tc, c1_wrap, c2_wrap, c1_err, c2_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] q;
      logic       wrap;
      logic       err;
      logic       tc;
      logic       chk_tc;
      logic       casc;
      logic [3:0] cq1;
      logic [3:0] cq2;
      logic       cw2;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   logic tc_pre;

   sync_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .din(din),
      .q(q), .tc(tc), .wrap(wrap), .err(err)
   );

   sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_c1 (
      .clk(clk), .reset(crst), .en(cen), .up(1'b1), .load(1'b0), .din(4'd0),
      .q(c1_q), .tc(c1_tc), .wrap(c1_wrap), .err(c1_err)
   );

   sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_c2 (
      .clk(clk), .reset(crst), .en(c1_tc), .up(1'b1), .load(1'b0), .din(4'd0),
      .q(c2_q), .tc(c2_tc), .wrap(c2_wrap), .err(c2_err)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   // Apply one cycle of inputs at negedge and queue the post-edge expectation.
   task automatic step(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] d, input logic [3:0] eq, input logic ew,
                       input logic ee, input logic etc, input logic ctc, input string nm);
      exp_t x;
      @(negedge clk);
      reset = r; en = e; up = u; load = l; din = d;
      x = '{q: eq, wrap: ew, err: ee, tc: etc, chk_tc: ctc, casc: 1'b0,
            cq1: 4'd0, cq2: 4'd0, cw2: 1'b0, name: nm};
      exp_q.push_back(x);
   endtask

   task automatic cstep(input logic r, input logic e, input int k, input string nm);
      exp_t x;
      @(negedge clk);
      crst = r; cen = e;
      x = '{q: 4'd0, wrap: 1'b0, err: 1'b0, tc: 1'b0, chk_tc: 1'b0, casc: 1'b1,
            cq1: 4'(k % 10), cq2: 4'((k / 10) % 10), cw2: (k == 100), name: nm};
      exp_q.push_back(x);
   endtask

   // tc is combinational: sample it once inputs have settled, before the edge.
   initial forever begin
      @(negedge clk);
      #1 tc_pre = tc;
   end

   // Monitor: every cycle the DUT presents new registered outputs, compare against the queue head.
   initial forever begin
      exp_t x;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         if (x.casc) begin
            chk({x.name, "_c1q"},   int'(c1_q),    int'(x.cq1));
            chk({x.name, "_c2q"},   int'(c2_q),    int'(x.cq2));
            chk({x.name, "_c2wrap"}, int'(c2_wrap), int'(x.cw2));
         end else begin
            chk({x.name, "_q"},    int'(q),    int'(x.q));
            chk({x.name, "_wrap"}, int'(wrap), int'(x.wrap));
            chk({x.name, "_err"},  int'(err),  int'(x.err));
            if (x.chk_tc) chk({x.name, "_tc"}, int'(tc_pre), int'(x.tc));
         end
      end
   end

   initial begin
      int waited;
      reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;
      crst = 1'b0; cen = 1'b0;

      // Reset dominates load and en
      step(0, 1, 1, 1, 4'd7, 4'd0, 0, 0, 0, 0, "rst0");
      step(0, 1, 1, 1, 4'd7, 4'd0, 0, 0, 0, 1, "rst1");

      // Count up 1..9, 0, 1, 2; tc while q==9, wrap after 9->0
      for (int i = 1; i <= 12; i++) begin
         step(1, 1, 1, 0, 4'd0, 4'(i % 10), (i == 10), 0, (i == 10), 1, $sformatf("up%0d", i));
      end

      // Load 0, then count down 9, 8, 7
      step(1, 0, 0, 1, 4'd0, 4'd0, 0, 0, 0, 1, "ld0");
      step(1, 1, 0, 0, 4'd0, 4'd9, 1, 0, 1, 1, "dn9");
      step(1, 1, 0, 0, 4'd0, 4'd8, 0, 0, 0, 1, "dn8");
      step(1, 1, 0, 0, 4'd0, 4'd7, 0, 0, 0, 1, "dn7");

      // Loads: in range, out of range, boundary values
      step(1, 0, 1, 1, 4'd5,  4'd5, 0, 0, 0, 1, "ld5");
      step(1, 0, 1, 1, 4'd12, 4'd9, 0, 1, 0, 1, "ld12");
      step(1, 0, 1, 0, 4'd0,  4'd9, 0, 0, 0, 1, "idle1");
      step(1, 0, 1, 0, 4'd0,  4'd9, 0, 0, 0, 1, "idle2");
      step(1, 0, 1, 1, 4'd10, 4'd9, 0, 1, 0, 1, "ld10");
      step(1, 0, 1, 1, 4'd9,  4'd9, 0, 0, 0, 1, "ld9");
      step(1, 0, 1, 1, 4'd15, 4'd9, 0, 1, 0, 1, "ld15");

      // Load with en high at q==9: no count, no wrap, tc still reflects q
      step(1, 1, 1, 1, 4'd3, 4'd3, 0, 0, 1, 1, "ldcnt");
      step(1, 1, 1, 0, 4'd0, 4'd4, 0, 0, 0, 1, "up4");
      step(1, 1, 1, 0, 4'd0, 4'd5, 0, 0, 0, 1, "up5");
      step(1, 1, 1, 0, 4'd0, 4'd6, 0, 0, 0, 1, "up6");
      step(0, 1, 1, 0, 4'd0, 4'd0, 0, 0, 0, 1, "midrst");

      // Direction flip at q==4
      for (int i = 1; i <= 4; i++) begin
         step(1, 1, 1, 0, 4'd0, 4'(i), 0, 0, 0, 1, $sformatf("fup%0d", i));
      end
      step(1, 1, 0, 0, 4'd0, 4'd3, 0, 0, 0, 1, "flip");
      step(1, 0, 0, 0, 4'd0, 4'd3, 0, 0, 0, 1, "hold");

      // Two-stage cascade counting 00..99 then back to 00
      cstep(0, 0, 0, "crst");
      for (int k = 1; k <= 100; k++) begin
         cstep(1, 1, k, $sformatf("casc%0d", k));
      end
      @(negedge clk);
      cen = 1'b0;

      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      #2;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
